bcd_timer_core: RTL and testbench
=================================

// Module: bcd_timer_core
// PURPOSE
//  Parametrised N-digit BCD up/down timer core for the stopwatch designs.
//  Counts in BCD at a programmable tick rate derived internally from the system clock, so no divided clock domain is needed.
//  Adds load, pause/resume, lap-hold display, terminal detection and a wrap/stop mode.
//  Sits between the one-pulse button front end and scan_ctl/display. digits_out feeds the scan inputs directly.
// PARAMETERS
//  DIGITS    2    number of BCD digits; digit 0 is least significant
//  TICK_DIV  100  clk cycles per count step (>=2); 100 gives 1 step/s at 100 Hz
//  WRAP      0    0: stop in DONE at terminal value; 1: wrap around and keep running
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous reset, active-high
//  start_stop_p  in   1          one-cycle pulse: start / pause / resume
//  clear_p       in   1          one-cycle pulse: clear count to 0, go IDLE
//  lap_p         in   1          one-cycle pulse: toggle lap hold
//  up_down       in   1          1 = count up, 0 = count down
//  load_en       in   1          load load_val (level, sampled each clk)
//  load_val      in   4*DIGITS   packed BCD preset
//  digits_out    out  4*DIGITS   packed BCD display value
//  running       out  1          1 while state == RUN
//  done          out  1          terminal indication (see below)
//  lap_active    out  1          1 while display is frozen
// BEHAVIOUR
//  Reset (async): state IDLE; count, prescaler, lap snapshot = 0; all outputs 0.
//  Event priority in the same cycle: clear_p > load_en > start_stop_p > lap_p.
//  Terminal value: all digits 9 when up_down=1, all digits 0 when up_down=0.
//  States:
//   IDLE:  start_stop_p -> RUN, prescaler := 0; ignored if count is terminal and WRAP=0.
//          load_en -> count := load_val, stays IDLE.
//   RUN:   prescaler += 1 each clk. At TICK_DIV-1 the prescaler returns to 0 and count steps by 1 in BCD.
//          The step ripples carry/borrow through all digits; up_down is sampled on that edge.
//          start_stop_p -> PAUSE; load_en ignored.
//          Step lands on terminal value and WRAP=0 -> DONE on the same edge.
//          WRAP=1: from terminal value the next step wraps (all 9 -> all 0 up, all 0 -> all 9 down).
//   PAUSE: count and prescaler hold; start_stop_p -> RUN, resuming from the held prescaler value.
//          load_en loads the count and goes to IDLE.
//   DONE:  count holds; start_stop_p ignored; load_en loads and goes IDLE.
//  clear_p in any state: count := 0, prescaler := 0, lap_active := 0, state := IDLE.
//  Load values: any load_val nibble > 9 is saturated to 9.
//  done output:
//   WRAP=0: level, 1 exactly while in DONE.
//   WRAP=1: one-clk pulse on the edge where a wrap step occurs.
//  Lap hold:
//   lap_p in RUN or PAUSE toggles lap_active.
//   On set, the snapshot takes the current count and digits_out shows the snapshot while the internal count continues.
//   On release, digits_out returns to the live count.
//   lap_p is ignored in IDLE/DONE. Entering DONE or IDLE clears lap_active.
//  digits_out = lap_active ? snapshot : count. Both are registers, so the display changes on the step edge; zero added latency.
//  running = (state == RUN), registered.
// TESTING (DIGITS=2, TICK_DIV=4)
//  1. WRAP=0, up_down=1: reset, start_stop_p, then 40 clk -> digits_out=8'h10, running=1, done=0.
//  2. WRAP=0: load_val=8'h98, start, 4 clk -> 8'h99, done=1, running=0.
//     Further start_stop_p is ignored. clear_p -> 8'h00, done=0.
//  3. WRAP=1, up_down=0: load 8'h01, start. 4 clk -> 8'h00. 8 clk -> 8'h99 with done high for exactly 1 clk.
//     load_val=8'hAB loads as 8'h99.
//  4. Pause: start, 10 clk, pause, hold 20 clk (count 8'h02 is stable), resume.
//     After 6 more clk -> 8'h04, i.e. count tracks total RUN clocks only.
//  5. Lap: run to 8'h05, lap_p -> digits_out stays 8'h05 for 12 clk.
//     lap_p -> digits_out=8'h08 and lap_active=0.
//  6. In RUN, clear_p and start_stop_p in the same cycle -> IDLE, 8'h00.
//     rst asserted mid-step -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/bcd_timer_core.sv
// N-digit BCD up/down timer with an internal tick prescaler, load, pause/resume,
// lap-hold display and terminal stop (WRAP=0) or wrap-around (WRAP=1).
module bcd_timer_core #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 100,
  parameter bit          WRAP     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_stop_p,
  input  logic                clear_p,
  input  logic                lap_p,
  input  logic                up_down,
  input  logic                load_en,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] digits_out,
  output logic                running,
  output logic                done,
  output logic                lap_active
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clamp every preset nibble above 9 down to 9.
  function automatic logic [CW-1:0] sat_load(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic is_terminal(input logic [CW-1:0] v, input logic up);
    logic t;
    t = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] != (up ? 4'd9 : 4'd0)) t = 1'b0;
    end
    return t;
  endfunction

  // One BCD step with carry/borrow ripple; MSB of the result is the ripple-out.
  function automatic logic [CW:0] bcd_step(input logic [CW-1:0] v, input logic up);
    logic [CW-1:0] r;
    logic          c;
    logic [3:0]    d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   snap_q, snap_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            lap_q, lap_d;
  logic [CW-1:0]   digits_q;
  logic            running_q;
  logic            done_q;
  logic [CW-1:0]   step_val;
  logic            step_ovf;
  logic [CW-1:0]   load_sat;
  logic            wrap_step;

  always_comb begin
    {step_ovf, step_val} = bcd_step(count_q, up_down);
    load_sat             = sat_load(load_val);
  end

  // Next-state: clear beats load beats start/stop beats lap.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    snap_d    = snap_q;
    presc_d   = presc_q;
    lap_d     = lap_q;
    wrap_step = 1'b0;

    if (clear_p) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
      lap_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_en) begin
            count_d = load_sat;
          end else if (start_stop_p && (WRAP || !is_terminal(count_q, up_down))) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (start_stop_p) begin
            state_d = ST_PAUSE;
          end else begin
            if (lap_p) begin
              if (!lap_q) snap_d = count_q;
              lap_d = !lap_q;
            end
            if (presc_q == PRESC_LAST) begin
              presc_d   = '0;
              count_d   = step_val;
              wrap_step = WRAP && step_ovf;
              if (!WRAP && is_terminal(step_val, up_down)) begin
                state_d = ST_DONE;
                lap_d   = 1'b0;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (load_en) begin
            count_d = load_sat;
            state_d = ST_IDLE;
            lap_d   = 1'b0;
          end else if (start_stop_p) begin
            state_d = ST_RUN;
          end else if (lap_p) begin
            if (!lap_q) snap_d = count_q;
            lap_d = !lap_q;
          end
        end
        ST_DONE: begin
          if (load_en) begin
            count_d = load_sat;
            state_d = ST_IDLE;
            lap_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      snap_q    <= '0;
      presc_q   <= '0;
      lap_q     <= 1'b0;
      digits_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      snap_q    <= snap_d;
      presc_q   <= presc_d;
      lap_q     <= lap_d;
      digits_q  <= lap_d ? snap_d : count_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= WRAP ? wrap_step : (state_d == ST_DONE);
    end
  end

  assign digits_out = digits_q;
  assign running    = running_q;
  assign done       = done_q;
  assign lap_active = lap_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Scoreboard bench: two DUTs (WRAP=0 / WRAP=1) share stimulus; each has an
// arithmetic reference model feeding an expected-output queue.
module tb_bcd_timer_core;

  localparam int TD  = 4;
  localparam int MOD = 100;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    int mode;
    int val;
    int ph;
    bit lap;
    int snap;
    bit pulse;
  } mdl_t;

  logic       clk, rst;
  logic       start_stop_p, clear_p, lap_p, up_down, load_en;
  logic [7:0] load_val;
  logic [7:0] dig0, dig1;
  logic       run0, run1, done0, done1, lap0, lap1;

  int compared, mismatched;
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  mdl_t m0, m1;
  bit   ud;
  logic [7:0] near_term [4] = '{8'h98, 8'h01, 8'h99, 8'h00};

  bcd_timer_core #(.DIGITS(2), .TICK_DIV(TD), .WRAP(1'b0)) u_dut_w0 (
    .clk(clk), .rst(rst), .start_stop_p(start_stop_p), .clear_p(clear_p),
    .lap_p(lap_p), .up_down(up_down), .load_en(load_en), .load_val(load_val),
    .digits_out(dig0), .running(run0), .done(done0), .lap_active(lap0));

  bcd_timer_core #(.DIGITS(2), .TICK_DIV(TD), .WRAP(1'b1)) u_dut_w1 (
    .clk(clk), .rst(rst), .start_stop_p(start_stop_p), .clear_p(clear_p),
    .lap_p(lap_p), .up_down(up_down), .load_en(load_en), .load_val(load_val),
    .digits_out(dig1), .running(run1), .done(done1), .lap_active(lap1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sat_val(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic bit is_term(input int v, input bit up);
    return up ? (v == MOD - 1) : (v == 0);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = M_IDLE; m.val = 0; m.ph = 0; m.lap = 1'b0; m.snap = 0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit wrap, input bit ss, input bit clr,
                                 input bit lp, input bit ld, input logic [7:0] lv, input bit up);
    mdl_t n;
    n = m;
    n.pulse = 1'b0;
    if (clr) begin
      n.mode = M_IDLE; n.val = 0; n.ph = 0; n.lap = 1'b0;
    end else if (m.mode == M_IDLE) begin
      if (ld) n.val = sat_val(lv);
      else if (ss && (wrap || !is_term(m.val, up))) begin
        n.mode = M_RUN; n.ph = 0;
      end
    end else if (m.mode == M_RUN) begin
      if (ss) n.mode = M_PAUSE;
      else begin
        if (lp) begin
          if (!m.lap) n.snap = m.val;
          n.lap = !m.lap;
        end
        n.ph = m.ph + 1;
        if (n.ph == TD) begin
          n.ph    = 0;
          n.val   = up ? (m.val + 1) % MOD : (m.val + MOD - 1) % MOD;
          n.pulse = wrap && is_term(m.val, up);
          if (!wrap && is_term(n.val, up)) begin
            n.mode = M_DONE; n.lap = 1'b0;
          end
        end
      end
    end else if (m.mode == M_PAUSE) begin
      if (ld) begin
        n.val = sat_val(lv); n.mode = M_IDLE; n.lap = 1'b0;
      end else if (ss) n.mode = M_RUN;
      else if (lp) begin
        if (!m.lap) n.snap = m.val;
        n.lap = !m.lap;
      end
    end else begin
      if (ld) begin
        n.val = sat_val(lv); n.mode = M_IDLE; n.lap = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] exp_of(input mdl_t m, input bit wrap);
    int   disp;
    logic d;
    disp = m.lap ? m.snap : m.val;
    d    = wrap ? m.pulse : (m.mode == M_DONE);
    return {to_bcd(disp), (m.mode == M_RUN), d, m.lap};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got digits=%h run=%b done=%b lap=%b, want digits=%h run=%b done=%b lap=%b",
               nm, $time, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the post-edge expectation.
  task automatic cycle(input bit ss, input bit clr, input bit lp, input bit ld, input logic [7:0] lv);
    @(negedge clk);
    rst          = 1'b0;
    start_stop_p = ss;
    clear_p      = clr;
    lap_p        = lp;
    load_en      = ld;
    load_val     = lv;
    up_down      = ud;
    m0 = mstep(m0, 1'b0, ss, clr, lp, ld, lv, ud);
    m1 = mstep(m1, 1'b1, ss, clr, lp, ld, lv, ud);
    q0.push_back(exp_of(m0, 1'b0));
    q1.push_back(exp_of(m1, 1'b1));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Reset asserted between edges must clear outputs without any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_w0", {dig0, run0, done0, lap0}, 11'h000);
    check("async_rst_w1", {dig1, run1, done1, lap1}, 11'h000);
    m0 = mreset();
    m1 = mreset();
    @(negedge clk);
    start_stop_p = 1'($urandom);
    lap_p        = 1'($urandom);
    q0.push_back(exp_of(m0, 1'b0));
    q1.push_back(exp_of(m1, 1'b1));
  endtask

  initial begin : mon_w0
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check("sb_wrap0", {dig0, run0, done0, lap0}, q0.pop_front());
    end
  end

  initial begin : mon_w1
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) check("sb_wrap1", {dig1, run1, done1, lap1}, q1.pop_front());
    end
  end

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b0; start_stop_p = 1'b0; clear_p = 1'b0; lap_p = 1'b0;
    up_down = 1'b1; load_en = 1'b0; load_val = 8'h00; ud = 1'b1;
    m0 = mreset(); m1 = mreset();
    #3 rst = 1'b1;
    #1;
    check("reset_w0", {dig0, run0, done0, lap0}, 11'h000);
    check("reset_w1", {dig1, run1, done1, lap1}, 11'h000);

    // Basic up count
    ud = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(40);
    // Terminal at 99, ignored start in DONE, clear
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    // Down count through 00, wrap, then saturated load
    ud = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(12);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hAB);
    idle(2);
    // Pause / resume
    ud = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(20);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(6);
    // Lap hold
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(20);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(12);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(4);
    // Clear beats start/stop; reset mid-step
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(6);
    async_reset();
    idle(3);

    // Randomised traffic with independent event pulses
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        logic [7:0] lv;
        if ($urandom_range(0, 63) == 0) ud = ~ud;
        lv = ($urandom_range(0, 2) == 0) ? near_term[$urandom_range(0, 3)] : 8'($urandom);
        cycle($urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, lv);
      end
    end

    idle(2);
    @(posedge clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
